// File: rtl/instr_decode_ctrl.sv
// Instruction decode/sequencing controller: accepts a fetched word, classifies its
// format, then walks it through execute, optional memory access and write-back.
module instr_decode_ctrl #(
  parameter int EX_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic [31:0] ir,
  output logic [2:0]  instr_type,
  output logic        ex_start,
  input  logic        ex_done,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        rf_we,
  output logic        retire,
  output logic        trap
);

  localparam logic [2:0] S_IDLE = 3'd0, S_DEC = 3'd1, S_EXEC = 3'd2,
                         S_MEM  = 3'd3, S_WB  = 3'd4, S_TRAP = 3'd5;

  localparam logic [2:0] INSTR_R = 3'd0, INSTR_I = 3'd1, INSTR_S = 3'd2,
                         INSTR_B = 3'd3, INSTR_U = 3'd4, INSTR_J = 3'd5;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;

  logic [2:0] state, nstate;
  logic [7:0] wait_cnt;
  logic       st_ret_q;
  logic [2:0] dec_type;
  logic       dec_legal;
  logic       is_ld, is_st, timeout, ok;

  assign is_ld   = (ir[6:0] == OP_LOAD);
  assign is_st   = (ir[6:0] == OP_STORE);
  assign timeout = (wait_cnt == 8'(EX_TIMEOUT - 1));
  assign ok      = rst_n & ~flush;

  always_comb begin
    dec_type  = instr_type;
    dec_legal = 1'b1;
    case (ir[6:0])
      7'b0110011:                                     dec_type = INSTR_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_type = INSTR_I;
      7'b0100011:                                     dec_type = INSTR_S;
      7'b1100011:                                     dec_type = INSTR_B;
      7'b0110111, 7'b0010111:                         dec_type = INSTR_U;
      7'b1101111:                                     dec_type = INSTR_J;
      default:                                        dec_legal = 1'b0;
    endcase
  end

  // Completion is tested before timeout so a same-cycle done/ack wins.
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: if (in_valid) nstate = S_DEC;
      S_DEC:  nstate = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC: if (ex_done)      nstate = (is_ld | is_st) ? S_MEM : S_WB;
              else if (timeout) nstate = S_TRAP;
      S_MEM:  if (mem_ack)      nstate = is_st ? S_IDLE : S_WB;
              else if (timeout) nstate = S_TRAP;
      S_WB, S_TRAP: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
    if (flush) nstate = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ir         <= 32'h0000_0013;
      instr_type <= INSTR_I;
      wait_cnt   <= 8'd0;
      st_ret_q   <= 1'b0;
    end else begin
      state <= nstate;
      if (state == S_IDLE && in_valid && !flush) ir <= in_instr;
      if (state == S_DEC && !flush && dec_legal) instr_type <= dec_type;
      if (nstate != state && (nstate == S_EXEC || nstate == S_MEM))
        wait_cnt <= 8'd0;
      else if ((state == S_EXEC && !ex_done) || (state == S_MEM && !mem_ack))
        wait_cnt <= wait_cnt + 8'd1;
      // A store retires the cycle after its ack, by which time we are back in IDLE.
      st_ret_q <= (state == S_MEM) && mem_ack && is_st && !flush;
    end
  end

  assign in_ready = ok & (state == S_IDLE);
  assign ex_start = ok & (state == S_EXEC) & (wait_cnt == 8'd0);
  assign mem_req  = ok & (state == S_MEM);
  assign mem_we   = mem_req & is_st;
  assign rf_we    = ok & (state == S_WB) & (ir[11:7] != 5'd0) &
                    (instr_type != INSTR_S) & (instr_type != INSTR_B);
  assign retire   = rst_n & ((ok & (state == S_WB)) | st_ret_q);
  assign trap     = ok & (state == S_TRAP);

endmodule
